fpu_sched: RTL and testbench

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_rr_arb.sv | 21 ++
 rtl/fpu_sched.sv | 127 ++++++++++++
 tb/tb_fpu_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU request scheduler.
//   - scheduler state enum
//   - result status codes (core pass-through codes plus the scheduler timeout code)
//   - operand format: 1 sign / 6 exponent / 25 mantissa bits, exponent bias 31
//   - helper to expand a requester id into a one-hot vector
package fpu_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned MAN_W  = 25;
    localparam int unsigned WORD_W = SIGN_W + EXP_W + MAN_W;
    localparam int unsigned BIAS   = 31;

    localparam logic [3:0] STATUS_EXACT     = 4'b0001;
    localparam logic [3:0] STATUS_OVERFLOW  = 4'b0011;
    localparam logic [3:0] STATUS_UNDERFLOW = 4'b0111;
    localparam logic [3:0] STATUS_INEXACT   = 4'b1111;
    localparam logic [3:0] STATUS_TIMEOUT   = 4'b1001;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } fpu_state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// fpu_rr_arb: two-requester round-robin grant.
//   req  - pending requests
//   ptr  - preferred requester; it wins when both request
//   gnt  - one-hot grant (all zero when nothing is pending)
// A lone request is granted whatever the pointer says.
module fpu_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (req[~ptr]) begin
            gnt[~ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: arbitrates two requesters onto a single floating-point adder core.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready pulses in IDLE only)
//   req_a, req_b          per-requester operands (1/6/25 format, bias 31)
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_data, rsp_status  response payload, qualified by rsp_valid
//   fpu_start             one-cycle launch pulse to the core
//   fpu_op_a, fpu_op_b    latched operands, stable from ISSUE until back in IDLE
//   fpu_done              core result strobe; honoured only in WAIT
//   fpu_data, fpu_status  core result, sampled with fpu_done
//   busy                  high whenever the scheduler is not in IDLE
//
// Build option: define FPU_SCHED_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES
// cycles, answering with data 0 and the timeout status. Without it WAIT has no bound.
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_status,
    output logic             fpu_start,
    output logic [31:0]      fpu_op_a,
    output logic [31:0]      fpu_op_b,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_data,
    input  logic [3:0]       fpu_status,
    output logic             busy
);

    fpu_state_e state_q;
    logic       ptr_q;      // preferred requester for the next simultaneous request
    logic       gnt_id_q;   // requester owning the in-flight operation
    logic [1:0] gnt;

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt_q;
`endif

    fpu_rr_arb u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // The grant is offered combinationally so a requester sees ready in the same cycle it
    // is accepted; masking with reset keeps ready low while reset is held.
    assign req_ready = (state_q == StIdle && reset) ? gnt : 2'b00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            gnt_id_q   <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_status <= '0;
            fpu_start  <= 1'b0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            busy       <= 1'b0;
`ifdef FPU_SCHED_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            fpu_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        gnt_id_q  <= gnt[1];
                        fpu_op_a  <= req_a[gnt[1]];
                        fpu_op_b  <= req_b[gnt[1]];
                        fpu_start <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
`ifdef FPU_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (fpu_done) begin
                        rsp_data   <= fpu_data;
                        rsp_status <= fpu_status;
                        rsp_valid  <= id_to_onehot(gnt_id_q);
                        state_q    <= StRespond;
`ifdef FPU_SCHED_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data   <= '0;
                        rsp_status <= STATUS_TIMEOUT;
                        rsp_valid  <= id_to_onehot(gnt_id_q);
                        state_q    <= StRespond;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end
                StRespond: begin
                    // Only the owner's rsp_ready completes the response.
                    if (rsp_ready[gnt_id_q]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        ptr_q     <= ~gnt_id_q;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sched.sv
module tb_fpu_sched;

    logic             clock;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic [3:0]       rsp_status;
    logic             fpu_start;
    logic [31:0]      fpu_op_a;
    logic [31:0]      fpu_op_b;
    logic             fpu_done;
    logic [31:0]      fpu_data;
    logic [3:0]       fpu_status;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_sched #(.TIMEOUT_CYCLES(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .fpu_start  (fpu_start),
        .fpu_op_a   (fpu_op_a),
        .fpu_op_b   (fpu_op_b),
        .fpu_done   (fpu_done),
        .fpu_data   (fpu_data),
        .fpu_status (fpu_status),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [1:0] oh(input int g);
        return (g != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in IDLE with req_valid already driven and no edge since; leaves in RESPOND.
    task automatic issue_op(input int g, input logic [31:0] res, input logic [3:0] st,
                            input bit drop, input string tag);
        #1;
        chk({tag, ".req_ready"}, {30'd0, req_ready}, {30'd0, oh(g)});
        tick();                                          // ISSUE
        if (drop) req_valid = 2'b00;
        chk({tag, ".fpu_start"}, {31'd0, fpu_start}, 32'd1);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".op_a"}, fpu_op_a, req_a[g]);
        chk({tag, ".op_b"}, fpu_op_b, req_b[g]);
        tick();                                          // WAIT
        chk({tag, ".start_pulse"}, {31'd0, fpu_start}, 32'd0);
        chk({tag, ".no_rsp_yet"}, {30'd0, rsp_valid}, 32'd0);
        fpu_done   = 1'b1;
        fpu_data   = res;
        fpu_status = st;
        tick();                                          // RESPOND, 3 cycles after accept
        fpu_done   = 1'b0;
        fpu_data   = 32'hDEAD_BEEF;
        fpu_status = 4'b0000;
        #1;
        chk({tag, ".rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh(g)});
        chk({tag, ".rsp_data"}, rsp_data, res);
        chk({tag, ".rsp_status"}, {28'd0, rsp_status}, {28'd0, st});
    endtask

    task automatic consume_op(input int g, input string tag);
        rsp_ready = oh(g);
        tick();
        rsp_ready = 2'b00;
        chk({tag, ".rsp_cleared"}, {30'd0, rsp_valid}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 2'b00;
        fpu_done   = 1'b0;
        fpu_data   = '0;
        fpu_status = '0;

        // Reset state
        #1;
        chk("rst.req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst.rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst.fpu_start", {31'd0, fpu_start}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        tick();

        // Single request: 1.0 + 1.0 = 2.0, exact
        req_a[0]  = 32'h3E00_0000;
        req_b[0]  = 32'h3E00_0000;
        req_a[1]  = 32'h3E80_0000;
        req_b[1]  = 32'h3F00_0000;
        req_valid = 2'b01;
        issue_op(0, 32'h4000_0000, 4'b0001, 1'b1, "single");
        consume_op(0, "single");

        // Simultaneous requests from reset alternate 0,1,0,1
        reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        req_valid = 2'b11;
        issue_op(0, 32'h1111_0000, 4'b0011, 1'b0, "rr0");
        consume_op(0, "rr0");
        issue_op(1, 32'h2222_0000, 4'b0111, 1'b0, "rr1");
        consume_op(1, "rr1");
        issue_op(0, 32'h3333_0000, 4'b1111, 1'b0, "rr2");
        consume_op(0, "rr2");
        issue_op(1, 32'h4444_0000, 4'b0001, 1'b0, "rr3");
        req_valid = 2'b00;
        consume_op(1, "rr3");

        // Backpressure: lone requester 1 wins despite pointer 0; response held 5 cycles
        req_valid = 2'b10;
        issue_op(1, 32'h5555_AAAA, 4'b0111, 1'b1, "bp");
        req_valid = 2'b01;
        rsp_ready = 2'b01;                               // non-owner ready is ignored
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp%0d.rsp_valid", k), {30'd0, rsp_valid}, 32'd2);
            chk($sformatf("bp%0d.rsp_data", k), rsp_data, 32'h5555_AAAA);
            chk($sformatf("bp%0d.rsp_status", k), {28'd0, rsp_status}, 32'd7);
            chk($sformatf("bp%0d.req_ready", k), {30'd0, req_ready}, 32'd0);
        end
        req_valid = 2'b00;
        consume_op(1, "bp");

        // Reset during WAIT drops the operation
        req_valid = 2'b01;
        #1;
        chk("rstw.accept", {30'd0, req_ready}, 32'd1);
        tick();                                          // ISSUE
        tick();                                          // WAIT
        reset = 1'b0;
        #1;
        chk("rstw.req_ready", {30'd0, req_ready}, 32'd0);
        chk("rstw.rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rstw.rsp_data", rsp_data, 32'd0);
        chk("rstw.rsp_status", {28'd0, rsp_status}, 32'd0);
        chk("rstw.fpu_start", {31'd0, fpu_start}, 32'd0);
        chk("rstw.op_a", fpu_op_a, 32'd0);
        chk("rstw.op_b", fpu_op_b, 32'd0);
        chk("rstw.busy", {31'd0, busy}, 32'd0);
        req_valid = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        chk("rstw.dropped", {30'd0, rsp_valid}, 32'd0);

        // Spurious fpu_done in IDLE
        fpu_done = 1'b1;
        fpu_data = 32'h1234_5678;
        tick();
        fpu_done = 1'b0;
        tick();
        chk("spur.rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("spur.busy", {31'd0, busy}, 32'd0);

        // Normal service after reset
        req_valid = 2'b01;
        issue_op(0, 32'h4000_0000, 4'b0001, 1'b1, "post");
        consume_op(0, "post");

`ifdef FPU_SCHED_TIMEOUT_EN
        // Core never answers: timeout after 16 WAIT cycles
        req_valid = 2'b01;
        #1;
        chk("to.accept", {30'd0, req_ready}, 32'd1);
        tick();                                          // ISSUE
        req_valid = 2'b00;
        tick();                                          // first WAIT cycle
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to.wait%0d", k), {30'd0, rsp_valid}, 32'd0);
            tick();
        end
        chk("to.rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("to.rsp_status", {28'd0, rsp_status}, 32'd9);
        chk("to.rsp_data", rsp_data, 32'd0);
        consume_op(0, "to");
`else
        // Without the timeout option WAIT holds until the core answers
        req_valid = 2'b01;
        #1;
        chk("hold.accept", {30'd0, req_ready}, 32'd1);
        tick();                                          // ISSUE
        req_valid = 2'b00;
        tick();                                          // WAIT
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("hold.wait%0d", k), {30'd0, rsp_valid}, 32'd0);
            tick();
        end
        chk("hold.busy", {31'd0, busy}, 32'd1);
        fpu_done   = 1'b1;
        fpu_data   = 32'h7777_0001;
        fpu_status = 4'b1111;
        tick();
        fpu_done   = 1'b0;
        chk("hold.rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("hold.rsp_data", rsp_data, 32'h7777_0001);
        chk("hold.rsp_status", {28'd0, rsp_status}, 32'd15);
        consume_op(0, "hold");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
